oob_dev: RTL and testbench

- Device-side SATA out-of-band responder: the counterpart of the host OOB controller that issues COMRESET, COMWAKE and ALIGN.
- Sits between the device GTX wrapper and the device link layer, in the usrclk2 domain.
- Answers COMRESET with COMINIT and COMWAKE with COMWAKE, then transmits ALIGN until the host echoes ALIGN.
- Sends SYNC until three back-to-back non-ALIGN primitives arrive, then asserts phy_ready and passes link-layer data through.

---
 rtl/oob_dev.sv | 191 +++++++++++++++++++
 tb/tb_oob_dev.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/oob_dev.sv
// Purpose : device-side SATA OOB responder; answers COMRESET with COMINIT and COMWAKE with COMWAKE,
//           then sends ALIGN and SYNC until the link is up, then passes link-layer data through.
// Latency : every output is registered, one cycle after the state/input that produces it.
// Backpressure: none; the GTX consumes one dword per clk, and OOB handshakes wait on txcomfinish.
// Ports   : clk/rst (sync, active-low); rxcominitdet_in, rxcomwakedet_in, rxelecidle_in,
//           rxbyteisaligned, txcomfinish, rxdata_in/rxcharisk_in, txdata_in/txcharisk_in in;
//           txcominit, txcomwake, txelecidle, txdata_out/txcharisk_out, rxdata_out/rxcharisk_out,
//           phy_ready out.
module oob_dev #(
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int TIMEOUT_CNT     = 40000,
    parameter int TIMER_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rxcominitdet_in,
    input  logic                           rxcomwakedet_in,
    input  logic                           rxelecidle_in,
    input  logic                           rxbyteisaligned,
    input  logic                           txcomfinish,
    input  logic [DATA_BYTE_WIDTH*8-1:0]   rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]     rxcharisk_in,
    input  logic [DATA_BYTE_WIDTH*8-1:0]   txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]     txcharisk_in,
    output logic                           txcominit,
    output logic                           txcomwake,
    output logic                           txelecidle,
    output logic [DATA_BYTE_WIDTH*8-1:0]   txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]     txcharisk_out,
    output logic [DATA_BYTE_WIDTH*8-1:0]   rxdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]     rxcharisk_out,
    output logic                           phy_ready
);
    localparam int DW = DATA_BYTE_WIDTH * 8;
    localparam int KW = DATA_BYTE_WIDTH;

    localparam logic [DW-1:0] ALIGN_DAT = 32'h7B4A4ABC;
    localparam logic [DW-1:0] SYNC_DAT  = 32'hB5B5957C;
    localparam logic [KW-1:0] PRIM_K    = 4'b0001;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] SEND_COMINIT = 3'd1;
    localparam logic [2:0] WAIT_COMWAKE = 3'd2;
    localparam logic [2:0] SEND_COMWAKE = 3'd3;
    localparam logic [2:0] WAIT_RXIDLE  = 3'd4;
    localparam logic [2:0] SEND_ALIGN   = 3'd5;
    localparam logic [2:0] SEND_SYNC    = 3'd6;
    localparam logic [2:0] READY        = 3'd7;

    logic [2:0]             state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [1:0]             nonalign_q, nonalign_d;
    logic                   txcominit_q, txcominit_d;
    logic                   txcomwake_q, txcomwake_d;
    logic                   txelecidle_q, txelecidle_d;
    logic [DW-1:0]          txdata_q, txdata_d;
    logic [KW-1:0]          txcharisk_q, txcharisk_d;
    logic                   phy_ready_q, phy_ready_d;
    logic [DW-1:0]          rxdata_q;
    logic [KW-1:0]          rxcharisk_q;

    logic rx_align;
    logic rx_nonalign_k;
    logic timeout;

    assign rx_align      = (rxdata_in == ALIGN_DAT) && (rxcharisk_in == PRIM_K);
    assign rx_nonalign_k = rxcharisk_in[0] && !rx_align;
    assign timeout       = (timer_q == TIMER_WIDTH'(TIMEOUT_CNT - 1));

    always_comb begin
        state_d    = state_q;
        nonalign_d = nonalign_q;
        case (state_q)
            IDLE: begin
                if (rxcominitdet_in) state_d = SEND_COMINIT;
            end
            SEND_COMINIT: begin
                if (txcomfinish) state_d = WAIT_COMWAKE;
            end
            WAIT_COMWAKE: begin
                // a retried COMRESET outranks a simultaneous COMWAKE
                if (rxcominitdet_in)      state_d = SEND_COMINIT;
                else if (rxcomwakedet_in) state_d = SEND_COMWAKE;
                else if (timeout)         state_d = IDLE;
            end
            SEND_COMWAKE: begin
                if (txcomfinish) state_d = WAIT_RXIDLE;
            end
            WAIT_RXIDLE: begin
                if (rxcominitdet_in)     state_d = SEND_COMINIT;
                else if (!rxelecidle_in) state_d = SEND_ALIGN;
            end
            SEND_ALIGN: begin
                if (rxcominitdet_in) begin
                    state_d = SEND_COMINIT;
                end else if (rxbyteisaligned && rx_align) begin
                    state_d    = SEND_SYNC;
                    nonalign_d = 2'd0;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            SEND_SYNC: begin
                if (rxcominitdet_in) begin
                    state_d = SEND_COMINIT;
                end else if (rx_nonalign_k) begin
                    // third back-to-back non-ALIGN primitive brings the link up
                    if (nonalign_q == 2'd2) state_d = READY;
                    nonalign_d = nonalign_q + 2'd1;
                end else begin
                    nonalign_d = 2'd0;
                end
            end
            READY: begin
                if (rxcominitdet_in) state_d = SEND_COMINIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer restarts on every state change, so it counts cycles spent in the current state.
    assign timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        txcominit_d  = (state_d == SEND_COMINIT) && (state_q != SEND_COMINIT);
        txcomwake_d  = (state_d == SEND_COMWAKE) && (state_q != SEND_COMWAKE);
        txelecidle_d = !((state_d == SEND_ALIGN) || (state_d == SEND_SYNC) || (state_d == READY));
        phy_ready_d  = (state_d == READY);
        txdata_d     = '0;
        txcharisk_d  = '0;
        case (state_d)
            SEND_ALIGN: begin
                txdata_d    = ALIGN_DAT;
                txcharisk_d = PRIM_K;
            end
            SEND_SYNC: begin
                txdata_d    = SYNC_DAT;
                txcharisk_d = PRIM_K;
            end
            READY: begin
                txdata_d    = txdata_in;
                txcharisk_d = txcharisk_in;
            end
            default: begin
                txdata_d    = '0;
                txcharisk_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            nonalign_q   <= 2'd0;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            txelecidle_q <= 1'b1;
            txdata_q     <= '0;
            txcharisk_q  <= '0;
            phy_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            nonalign_q   <= nonalign_d;
            txcominit_q  <= txcominit_d;
            txcomwake_q  <= txcomwake_d;
            txelecidle_q <= txelecidle_d;
            txdata_q     <= txdata_d;
            txcharisk_q  <= txcharisk_d;
            phy_ready_q  <= phy_ready_d;
        end
    end

    // Receive path is a plain one-cycle bypass, independent of state and reset.
    always_ff @(posedge clk) begin
        rxdata_q    <= rxdata_in;
        rxcharisk_q <= rxcharisk_in;
    end

    assign txcominit     = txcominit_q;
    assign txcomwake     = txcomwake_q;
    assign txelecidle    = txelecidle_q;
    assign txdata_out    = txdata_q;
    assign txcharisk_out = txcharisk_q;
    assign phy_ready     = phy_ready_q;
    assign rxdata_out    = rxdata_q;
    assign rxcharisk_out = rxcharisk_q;

endmodule

// File: tb/tb_oob_dev.sv
// Purpose : directed bench for oob_dev: handshake, timeouts, SYNC counting, restart and reset.
// Latency : checks one cycle after each driven step (all DUT outputs are registered).
// Backpressure: n/a; expected rx/tx pass-through values are queued when driven and popped on output.
module tb_oob_dev;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;
    localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] D102  = 32'h4A4A4A4A;

    logic        clk;
    logic        rst;
    logic        rxcominitdet_in, rxcomwakedet_in, rxelecidle_in, rxbyteisaligned, txcomfinish;
    logic [31:0] rxdata_in, txdata_in, txdata_out, rxdata_out;
    logic [3:0]  rxcharisk_in, txcharisk_in, txcharisk_out, rxcharisk_out;
    logic        txcominit, txcomwake, txelecidle, phy_ready;

    int checks = 0;
    int errors = 0;
    int ncominit = 0;
    int ncomwake = 0;

    logic [35:0] rxq[$];
    logic [35:0] txq[$];

    oob_dev #(.DATA_BYTE_WIDTH(4), .TIMEOUT_CNT(100), .TIMER_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .rxcominitdet_in (rxcominitdet_in),
        .rxcomwakedet_in (rxcomwakedet_in),
        .rxelecidle_in   (rxelecidle_in),
        .rxbyteisaligned (rxbyteisaligned),
        .txcomfinish     (txcomfinish),
        .rxdata_in       (rxdata_in),
        .rxcharisk_in    (rxcharisk_in),
        .txdata_in       (txdata_in),
        .txcharisk_in    (txcharisk_in),
        .txcominit       (txcominit),
        .txcomwake       (txcomwake),
        .txelecidle      (txelecidle),
        .txdata_out      (txdata_out),
        .txcharisk_out   (txcharisk_out),
        .rxdata_out      (rxdata_out),
        .rxcharisk_out   (rxcharisk_out),
        .phy_ready       (phy_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txcominit === 1'b1) ncominit++;
        if (txcomwake === 1'b1) ncomwake++;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // packed as {txcominit, txcomwake, txelecidle, phy_ready, txcharisk_out, txdata_out}
    task automatic chk_out(input string tag, input logic ci, input logic cw, input logic ei,
                           input logic [31:0] d, input logic [3:0] k, input logic pr);
        chk(tag, {txcominit, txcomwake, txelecidle, phy_ready, txcharisk_out, txdata_out},
                 {ci, cw, ei, pr, k, d});
    endtask

    // one clock; rx bypass scoreboard entry pushed before the edge and checked after it
    task automatic tick();
        logic [35:0] exp;
        rxq.push_back({rxcharisk_in, rxdata_in});
        @(posedge clk);
        #1;
        exp = rxq.pop_front();
        chk("rx_bypass", {4'h0, rxcharisk_out, rxdata_out}, {4'h0, exp});
    endtask

    initial begin
        logic [35:0] texp;
        rst = 1'b0;
        rxcominitdet_in = 1'b0; rxcomwakedet_in = 1'b0; rxelecidle_in = 1'b1;
        rxbyteisaligned = 1'b0; txcomfinish = 1'b0;
        rxdata_in = '0; rxcharisk_in = '0; txdata_in = '0; txcharisk_in = '0;

        tick(); tick();
        chk_out("reset", 0, 0, 1, 32'h0, 4'h0, 0);
        rst = 1'b1;
        tick();
        chk_out("idle", 0, 0, 1, 32'h0, 4'h0, 0);

        // full handshake
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        chk_out("cominit_pulse", 1, 0, 1, 32'h0, 4'h0, 0);
        repeat (9) tick();
        chk_out("cominit_hold", 0, 0, 1, 32'h0, 4'h0, 0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        repeat (3) tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        chk_out("comwake_pulse", 0, 1, 1, 32'h0, 4'h0, 0);
        tick();
        chk_out("comwake_hold", 0, 0, 1, 32'h0, 4'h0, 0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        repeat (2) tick();
        chk_out("wait_rxidle", 0, 0, 1, 32'h0, 4'h0, 0);
        rxelecidle_in = 1'b0; rxdata_in = D102; rxcharisk_in = 4'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_out("align_tx", 0, 0, 0, ALIGN, 4'h1, 0);
        end
        rxdata_in = ALIGN; rxcharisk_in = 4'h1; rxbyteisaligned = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("sync_tx", 0, 0, 0, SYNC, 4'h1, 0);
        end

        // SYNC count broken by an ALIGN, then three clean non-ALIGN primitives
        rxdata_in = SYNC; tick(); tick();
        rxdata_in = ALIGN; tick();
        chk_out("sync_broken", 0, 0, 0, SYNC, 4'h1, 0);
        rxdata_in = HOLD; tick(); tick();
        chk_out("sync_two", 0, 0, 0, SYNC, 4'h1, 0);
        txdata_in = 32'hDEADBEEF; txcharisk_in = 4'h0;
        tick();
        chk_out("ready", 0, 0, 0, 32'hDEADBEEF, 4'h0, 1);
        chk("cominit_count", 40'(ncominit), 40'd1);
        chk("comwake_count", 40'(ncomwake), 40'd1);

        // READY pass-through with random link-layer and rx traffic
        for (int i = 0; i < 8; i++) begin
            txdata_in = $urandom; txcharisk_in = 4'($urandom_range(0, 15));
            rxdata_in = $urandom; rxcharisk_in = 4'($urandom_range(0, 15));
            txq.push_back({txcharisk_in, txdata_in});
            tick();
            texp = txq.pop_front();
            chk_out("ready_pass", 0, 0, 0, texp[31:0], texp[35:32], 1);
        end

        // COMRESET while READY; txcomfinish in the SEND_COMINIT entry cycle
        rxelecidle_in = 1'b1; rxdata_in = '0; rxcharisk_in = '0;
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        chk_out("comreset_ready", 1, 0, 1, 32'h0, 4'h0, 0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        chk_out("entry_finish", 0, 0, 1, 32'h0, 4'h0, 0);

        // COMWAKE timeout: 100 cycles in WAIT_COMWAKE, then a COMWAKE is ignored
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_out("wait_comwake", 0, 0, 1, 32'h0, 4'h0, 0);
        end
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        chk_out("timeout_no_comwake", 0, 0, 1, 32'h0, 4'h0, 0);
        tick();

        // COMWAKE on the last cycle before timeout is still answered
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        repeat (99) tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        chk_out("comwake_at_limit", 0, 1, 1, 32'h0, 4'h0, 0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;

        // ALIGN timeout: host sends only D10.2
        rxelecidle_in = 1'b0; rxdata_in = D102; rxcharisk_in = 4'h0;
        tick();
        chk_out("align_start", 0, 0, 0, ALIGN, 4'h1, 0);
        repeat (98) tick();
        tick();
        chk_out("align_last", 0, 0, 0, ALIGN, 4'h1, 0);
        tick();
        chk_out("align_timeout", 0, 0, 1, 32'h0, 4'h0, 0);
        repeat (3) tick();
        chk_out("align_timeout_idle", 0, 0, 1, 32'h0, 4'h0, 0);

        // reset in the middle of SEND_ALIGN
        rxelecidle_in = 1'b1;
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        rxelecidle_in = 1'b0; tick(); tick();
        chk_out("align_before_rst", 0, 0, 0, ALIGN, 4'h1, 0);
        rst = 1'b0; tick(); rst = 1'b1;
        chk_out("reset_mid", 0, 0, 1, 32'h0, 4'h0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("no_align_after_rst", 0, 0, 1, 32'h0, 4'h0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
